universal_bound_counter: RTL
============================

Name: universal_bound_counter

Overview:
- Parametrised next-generation universal bidirectional counter: hold, count up, count down and parallel load.
- Count bounds and step size are run-time inputs rather than fixed parameters.
- Each direction can either wrap around or saturate at its bound.
- Provides a combinational cascade carry (TerminalCount), a registered wrap pulse and a sticky boundary flag. Used as a timebase/digit counter in lab datapaths and chainable through Enable/TerminalCount.

Parameters:
- LENGTH, 8, counter width in bits.
- STEP_WIDTH, 4, width of the Step input.
- InitialCount, 0, value of Q after reset.

Ports:
- CLOCK  input  1  single clock, rising edge.
- ResetN  input  1  reset, asynchronous, active-low.
- S  input  2  mode: 0 hold, 1 count up, 2 count down, 3 parallel load.
- Enable  input  1  count enable; gates modes 1/2 only.
- Saturate  input  1  1 = saturate at bound, 0 = wrap.
- BeginCount  input  LENGTH  lower bound, inclusive.
- EndCount  input  LENGTH  upper bound, inclusive.
- Step  input  STEP_WIDTH  increment/decrement amount; 0 treated as 1.
- P  input  LENGTH  parallel load value.
- ClearFlag  input  1  synchronous clear of OverflowFlag.
- Q  output  LENGTH  count, registered.
- TerminalCount  output  1  combinational carry: the next edge hits a bound.
- WrapPulse  output  1  registered 1-cycle pulse after a wrap.
- OverflowFlag  output  1  sticky: set by any wrap or saturation.
- BoundErr  output  1  combinational: BeginCount > EndCount.

Behaviour:
- Reset (ResetN=0, asynchronous): Q=InitialCount, WrapPulse=0, OverflowFlag=0. Reset is held regardless of CLOCK. Release takes effect at the next rising edge.
- Effective step: Se = (Step==0) ? 1 : Step. Width rules:
  - Up sum: Q+Se computed in LENGTH+1 bits; no silent truncation.
  - Down difference: Q-Se computed in LENGTH+1 bits, with the borrow detected.
- Hit-up: Q+Se > EndCount (wide compare). This includes Q already above EndCount.
- Hit-down: Q < BeginCount+Se (wide), i.e. Q-Se would fall below BeginCount, including on borrow.
- Mode 0, or mode 1/2 with Enable=0: Q holds.
- Mode 1, Enable=1:
  - not hit-up: Q <= Q+Se.
  - hit-up with Saturate=0: Q <= BeginCount (wrap).
  - hit-up with Saturate=1: Q <= EndCount.
- Mode 2, Enable=1:
  - not hit-down: Q <= Q-Se.
  - hit-down with Saturate=0: Q <= EndCount (wrap).
  - hit-down with Saturate=1: Q <= BeginCount.
- Mode 3 (independent of Enable): Q <= P clamped to the bounds.
  - P > EndCount: loads EndCount.
  - P < BeginCount: loads BeginCount.
  - Clamping does not set OverflowFlag.
- BoundErr=1: modes 1, 2 and 3 all act as hold. Q, WrapPulse and OverflowFlag do not update, except that ClearFlag still clears OverflowFlag.
- TerminalCount = Enable & !BoundErr & ((S==1 & hit-up) | (S==2 & hit-down)). It is combinational so cascaded stages' Enable can be driven from it in the same cycle.
- WrapPulse: registered. It is 1 for exactly the cycle after an edge on which a wrap (Saturate=0) occurred, otherwise 0. A saturation never pulses.
- OverflowFlag: set on any edge where TerminalCount=1 (wrap or saturation). Cleared by ClearFlag=1. Simultaneous set and clear: set wins.
- Saturated and held at a bound while still counting: TerminalCount stays 1 every cycle and OverflowFlag stays set.
- Bounds changed while counting: Q outside the new range is corrected on the next count edge via the hit rules. There is no spontaneous change in hold mode.
- BeginCount==EndCount is valid. The counter stays at that value and TerminalCount=1 whenever counting is enabled.
- Latency: every Q update is one clock edge; no pipeline stages.

Test Plan:
- Reset/wrap up (LENGTH=8, reset to InitialCount=0, Begin=0, End=9, Step=1, S=1, Enable=1, Saturate=0): Q runs 0..9 then 0. TerminalCount=1 only while Q=9. WrapPulse=1 on the cycle Q=0 after wrap. OverflowFlag=1 thereafter.
- Step and saturation (Begin=10, End=50, Step=7, Saturate=1, start Q=10):
  - up: Q = 10,17,24,31,38,45,50,50. TerminalCount=1 at Q=45 and Q=50. WrapPulse never 1.
  - down from 50: Q = 43,...,15,10,10.
- Down wrap with borrow (Begin=0, End=200, Step=5, Q=3, S=2, Saturate=0): next Q=200 (no underflow to 254). TerminalCount=1 before that edge.
- Load clamp and Enable (Begin=20, End=100, S=3, Enable=0):
  - P=150: Q=100.
  - P=5: Q=20.
  - P=60: Q=60.
  - then S=1 with Enable=0: Q holds 60.
- Flag and async reset:
  - ClearFlag asserted on the same edge as a wrap: OverflowFlag stays 1.
  - ClearFlag alone: OverflowFlag goes to 0.
  - ResetN pulsed low mid-cycle: Q=InitialCount immediately, before the next CLOCK edge.
- BoundErr (Begin=30, End=10): BoundErr=1 and Q holds under S=1/2/3. Restoring the bounds resumes counting.

Source files
------------

// File: rtl/universal_bound_counter.sv
// -----------------------------------------------------------------------------
// universal_bound_counter
//
// Bidirectional counter with run-time bounds and step size. Supports hold,
// count up, count down and a clamped parallel load. Each direction either
// wraps to the opposite bound or saturates at its own bound.
//
// Ports
//   CLOCK          in   1           rising-edge clock
//   ResetN         in   1           asynchronous active-low reset
//   S              in   2           mode: 0 hold, 1 up, 2 down, 3 load
//   Enable         in   1           count enable (gates modes 1/2 only)
//   Saturate       in   1           1 = saturate at bound, 0 = wrap
//   BeginCount     in   LENGTH      lower bound, inclusive
//   EndCount       in   LENGTH      upper bound, inclusive
//   Step           in   STEP_WIDTH  step amount, 0 behaves as 1
//   P              in   LENGTH      parallel load value
//   ClearFlag      in   1           synchronous clear of OverflowFlag
//   Q              out  LENGTH      registered count
//   TerminalCount  out  1           combinational: next edge hits a bound
//   WrapPulse      out  1           registered one-cycle pulse after a wrap
//   OverflowFlag   out  1           sticky wrap/saturation flag
//   BoundErr       out  1           combinational: BeginCount > EndCount
// -----------------------------------------------------------------------------
module universal_bound_counter #(
    parameter int                LENGTH       = 8,
    parameter int                STEP_WIDTH   = 4,
    parameter logic [LENGTH-1:0] InitialCount = '0
) (
    input  logic                  CLOCK,
    input  logic                  ResetN,
    input  logic [1:0]            S,
    input  logic                  Enable,
    input  logic                  Saturate,
    input  logic [LENGTH-1:0]     BeginCount,
    input  logic [LENGTH-1:0]     EndCount,
    input  logic [STEP_WIDTH-1:0] Step,
    input  logic [LENGTH-1:0]     P,
    input  logic                  ClearFlag,
    output logic [LENGTH-1:0]     Q,
    output logic                  TerminalCount,
    output logic                  WrapPulse,
    output logic                  OverflowFlag,
    output logic                  BoundErr
);

    // Wide enough that both Q+Se and BeginCount+Se never overflow.
    localparam int WW = ((LENGTH > STEP_WIDTH) ? LENGTH : STEP_WIDTH) + 1;

    localparam logic [1:0] MODE_HOLD = 2'd0;
    localparam logic [1:0] MODE_UP   = 2'd1;
    localparam logic [1:0] MODE_DOWN = 2'd2;
    localparam logic [1:0] MODE_LOAD = 2'd3;

    // Clamp a load value into [b, e]; only meaningful when b <= e.
    function automatic logic [LENGTH-1:0] clamp_load(
        input logic [LENGTH-1:0] p,
        input logic [LENGTH-1:0] b,
        input logic [LENGTH-1:0] e
    );
        logic [LENGTH-1:0] v;
        if (p > e) begin
            v = e;
        end else if (p < b) begin
            v = b;
        end else begin
            v = p;
        end
        return v;
    endfunction

    logic [LENGTH-1:0] r_q;
    logic              r_wrap_pulse;
    logic              r_overflow;

    logic [WW-1:0]     w_se;
    logic [WW-1:0]     w_q_wide;
    logic [WW-1:0]     w_begin_wide;
    logic [WW-1:0]     w_end_wide;
    logic [WW-1:0]     w_up_sum;
    logic [WW-1:0]     w_down_floor;
    logic [LENGTH-1:0] w_down_next;
    logic              w_hit_up;
    logic              w_hit_down;
    logic              w_bound_err;
    logic              w_term_count;
    logic              w_wrap;
    logic [LENGTH-1:0] w_q_next;

    assign w_se         = (Step == {STEP_WIDTH{1'b0}})
                        ? {{(WW-1){1'b0}}, 1'b1}
                        : {{(WW-STEP_WIDTH){1'b0}}, Step};
    assign w_q_wide     = {{(WW-LENGTH){1'b0}}, r_q};
    assign w_begin_wide = {{(WW-LENGTH){1'b0}}, BeginCount};
    assign w_end_wide   = {{(WW-LENGTH){1'b0}}, EndCount};
    assign w_up_sum     = w_q_wide + w_se;
    assign w_down_floor = w_begin_wide + w_se;

    // Hit-down compares Q against Begin+Se so a borrow can never slip through.
    assign w_hit_up     = (w_up_sum > w_end_wide);
    assign w_hit_down   = (w_q_wide < w_down_floor);

    // When not hit-down, Se <= Q < 2^LENGTH, so the narrow subtraction is exact.
    assign w_down_next  = r_q - w_se[LENGTH-1:0];

    assign w_bound_err  = (BeginCount > EndCount);
    assign w_term_count = Enable & ~w_bound_err &
                          (((S == MODE_UP) & w_hit_up) | ((S == MODE_DOWN) & w_hit_down));
    assign w_wrap       = w_term_count & ~Saturate;

    // Next-count selection for every mode; invalid bounds force a hold.
    always_comb begin
        w_q_next = r_q;
        if (w_bound_err) begin
            w_q_next = r_q;
        end else begin
            case (S)
                MODE_HOLD: begin
                    w_q_next = r_q;
                end
                MODE_UP: begin
                    if (!Enable) begin
                        w_q_next = r_q;
                    end else if (w_hit_up) begin
                        w_q_next = Saturate ? EndCount : BeginCount;
                    end else begin
                        w_q_next = w_up_sum[LENGTH-1:0];
                    end
                end
                MODE_DOWN: begin
                    if (!Enable) begin
                        w_q_next = r_q;
                    end else if (w_hit_down) begin
                        w_q_next = Saturate ? BeginCount : EndCount;
                    end else begin
                        w_q_next = w_down_next;
                    end
                end
                MODE_LOAD: begin
                    w_q_next = clamp_load(P, BeginCount, EndCount);
                end
                default: begin
                    w_q_next = r_q;
                end
            endcase
        end
    end

    // Count, wrap pulse and sticky overflow state; set beats clear.
    always_ff @(posedge CLOCK or negedge ResetN) begin
        if (!ResetN) begin
            r_q          <= InitialCount;
            r_wrap_pulse <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_q          <= w_q_next;
            r_wrap_pulse <= w_wrap;
            if (w_term_count) begin
                r_overflow <= 1'b1;
            end else if (ClearFlag) begin
                r_overflow <= 1'b0;
            end else begin
                r_overflow <= r_overflow;
            end
        end
    end

    assign Q             = r_q;
    assign WrapPulse     = r_wrap_pulse;
    assign OverflowFlag  = r_overflow;
    assign TerminalCount = w_term_count;
    assign BoundErr      = w_bound_err;

endmodule
